fixed_point_sign_scheduler: RTL and testbench
=============================================

FIXED_POINT_SIGN_SCHEDULER -- requirements
Module: FIXED_POINT_SIGN_SCHEDULER

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of all values.
REQ-002 SHALL have parameter FRAC_BITS, default 3, fractional bits; passed through only, no arithmetic here.
REQ-003 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-004 SHALL have parameter TIMEOUT, default 15, maximum WAIT cycles before error response.
REQ-005 SHALL have port CLK  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port RSTN  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port REQ_VALID  input  NUM_REQ  per-requester request valid.
REQ-008 SHALL have port REQ_READY  output  NUM_REQ  per-requester accept; at most one bit high.
REQ-009 SHALL have port REQ_VALUE  input  NUM_REQ*WIDTH  signed operands; requester i in slice [i*WIDTH +: WIDTH].
REQ-010 SHALL have port REQ_SIGN  input  NUM_REQ  target sign per requester (0 positive, 1 negative).
REQ-011 SHALL have port RSP_VALID  output  NUM_REQ  one-cycle response strobe to owning requester.
REQ-012 SHALL have port RSP_VALUE  output  WIDTH  result, shared by all requesters.
REQ-013 SHALL have port RSP_ERR  output  1  qualifies RSP_VALID: timeout occurred.
REQ-014 SHALL have ports CS_TARGET_SIGN, CS_VALUE_IN (WIDTH), CS_VALID_IN outputs, and CS_VALUE_OUT (WIDTH), CS_VALID_OUT inputs, to the single shared change-sign unit.
REQ-015 SHALL have port BUSY  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; one operation in flight at any time.
REQ-017 In IDLE, SHALL select grant index by round-robin among asserted REQ_VALID bits, starting search at pointer RR_PTR, and assert REQ_READY[grant] combinationally.
REQ-018 On REQ_VALID[g] & REQ_READY[g] in IDLE, SHALL capture operand, target sign and owner index g, and go to ISSUE.
REQ-019 In ISSUE, SHALL drive CS_VALID_IN=1 for exactly one cycle with captured operand and sign, clear wait counter, go to WAIT.
REQ-020 In WAIT, SHALL increment wait counter each cycle; on CS_VALID_OUT, register CS_VALUE_OUT into RSP_VALUE, RSP_ERR=0, go to RESP.
REQ-021 In WAIT, when counter reaches TIMEOUT without CS_VALID_OUT, SHALL set RSP_VALUE=0, RSP_ERR=1, go to RESP; CS_VALID_OUT on that same cycle takes priority (normal response).
REQ-022 In RESP, SHALL assert RSP_VALID[owner] for one cycle, set RR_PTR=(owner+1) mod NUM_REQ, return to IDLE.
REQ-023 SHALL ignore CS_VALID_OUT in IDLE, ISSUE and RESP (stray/late results discarded).
REQ-024 Latency: acceptance at cycle T -> CS_VALID_IN at T+1 -> for unit result at T+1+L, RSP_VALID at T+2+L; next acceptance no earlier than T+3+L.
REQ-025 RSP_VALUE and RSP_ERR SHALL hold until the next RESP; REQ_READY SHALL be all-zero outside IDLE.
REQ-026 Wait counter SHALL be ceil(log2(TIMEOUT+1)) bits and SHALL not wrap.

Reset
REQ-027 On RSTN=0 at a clock edge: state IDLE, RR_PTR=0, counter 0, RSP_VALID=0, RSP_VALUE=0, RSP_ERR=0, CS_VALID_IN=0, CS_VALUE_IN=0, CS_TARGET_SIGN=0.
REQ-028 Reset mid-operation SHALL abandon the in-flight operation with no response; late CS_VALID_OUT after reset is discarded per REQ-023.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding (2-bit) and default parameter constants.
REQ-030 Round-robin selection SHALL be a sub-module RR_ARBITER (inputs request vector and pointer, outputs one-hot grant and index).

Verification
REQ-031 Req 0: 0x10 (+2.0), sign 1; model returns 0xF0 after L=3 -> RSP_VALID[0] at T+5, RSP_VALUE=0xF0, RSP_ERR=0.
REQ-032 Req 2: 0xE8 (-3.0), sign 1; model bypass, L=1 -> RSP_VALUE=0xE8 at T+3.
REQ-033 All four REQ_VALID held high, RR_PTR=0 -> grant order 0,1,2,3,0; each requester exactly one RSP per round.
REQ-034 Model never answers -> RSP_VALID[owner] with RSP_ERR=1, RSP_VALUE=0 exactly TIMEOUT WAIT cycles after issue.
REQ-035 CS_VALID_OUT exactly at timeout cycle -> normal response, RSP_ERR=0.
REQ-036 RSTN low two cycles during WAIT -> no RSP_VALID, BUSY=0, RR_PTR=0; late CS_VALID_OUT ignored; next request served normally.

Source files
------------

// File: rtl/fixed_point_sign_scheduler_pkg.sv
// Shared definitions for the fixed-point sign scheduler: FSM state encoding
// and the default parameter values used by the top level.
package fixed_point_sign_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_FRAC_BITS = 3;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_TIMEOUT   = 15;

endpackage

// File: rtl/fixed_point_sign_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after the
// pointer position (wrapping), returning a one-hot grant and its index.
module fixed_point_sign_scheduler_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               grant_vld
);

    localparam logic [IW:0] N_W = (IW+1)'(NUM_REQ);

    logic [NUM_REQ-1:0] rot;
    logic [IW-1:0]      offset;
    logic [IW:0]        sum;

    // Rotate requests so the pointer position sits at bit 0, take the lowest
    // set bit, then map the offset back to an absolute requester index.
    always_comb begin
        rot       = NUM_REQ'({req, req} >> ptr);
        grant_vld = 1'b0;
        offset    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                grant_vld = 1'b1;
                offset    = IW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        grant_idx = sum[IW-1:0];
        grant     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            grant[k] = grant_vld && (grant_idx == IW'(k));
        end
    end

endmodule

// File: rtl/fixed_point_sign_scheduler.sv
// Schedules sign-change operations from several requesters onto one shared
// change-sign unit: round-robin grant, issue, bounded wait for the result,
// then a one-cycle response strobe to the owning requester.
module fixed_point_sign_scheduler
    import fixed_point_sign_scheduler_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic [NUM_REQ-1:0]        REQ_VALID,
    output logic [NUM_REQ-1:0]        REQ_READY,
    input  logic [NUM_REQ*WIDTH-1:0]  REQ_VALUE,
    input  logic [NUM_REQ-1:0]        REQ_SIGN,
    output logic [NUM_REQ-1:0]        RSP_VALID,
    output logic signed [WIDTH-1:0]   RSP_VALUE,
    output logic                      RSP_ERR,
    output logic                      CS_TARGET_SIGN,
    output logic signed [WIDTH-1:0]   CS_VALUE_IN,
    output logic                      CS_VALID_IN,
    input  logic signed [WIDTH-1:0]   CS_VALUE_OUT,
    input  logic                      CS_VALID_OUT,
    output logic                      BUSY
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

    // FRAC_BITS only documents the operand format; nothing here depends on it
    // beyond it having to fit inside the word.
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..16");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end
    if (FRAC_BITS < 0 || FRAC_BITS > WIDTH) begin : g_bad_frac
        $error("FRAC_BITS must lie within 0..WIDTH");
    end

    state_t                  state;
    state_t                  state_nxt;
    logic [IW-1:0]           rr_ptr;
    logic [IW-1:0]           owner;
    logic [NUM_REQ-1:0]      grant;
    logic [IW-1:0]           grant_idx;
    logic                    grant_vld;
    logic [CW-1:0]           wait_cnt;
    logic signed [WIDTH-1:0] sel_value;
    logic                    sel_sign;
    logic                    accept;
    logic                    wait_done;

    // Wait counter saturates at TIMEOUT so it can never wrap back to zero.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Pointer position just after a requester, wrapping at NUM_REQ.
    function automatic logic [IW-1:0] rr_after(input logic [IW-1:0] idx);
        return (idx == IDX_LAST) ? '0 : idx + 1'b1;
    endfunction

    fixed_point_sign_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_arbiter (
        .req       (REQ_VALID),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign accept    = (state == ST_IDLE) && grant_vld;
    assign wait_done = CS_VALID_OUT || (wait_cnt == CNT_LAST);

    assign REQ_READY   = (state == ST_IDLE) ? grant : '0;
    assign BUSY        = (state != ST_IDLE);
    assign CS_VALID_IN = (state == ST_ISSUE);

    // Select the granted requester's operand and target sign.
    always_comb begin
        sel_value = '0;
        sel_sign  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == IW'(k)) begin
                sel_value = REQ_VALUE[k*WIDTH +: WIDTH];
                sel_sign  = REQ_SIGN[k];
            end
        end
    end

    // Response strobe goes only to the owner, and only while in RESP.
    always_comb begin
        RSP_VALID = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            RSP_VALID[k] = (state == ST_RESP) && (owner == IW'(k));
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; a result arriving on the last WAIT cycle wins
    // over the timeout because wait_done covers both the same way.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (wait_done) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Operation capture, wait counting, result/timeout registration and
    // round-robin pointer update. Results outside WAIT are dropped.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            rr_ptr         <= '0;
            owner          <= '0;
            wait_cnt       <= '0;
            CS_VALUE_IN    <= '0;
            CS_TARGET_SIGN <= 1'b0;
            RSP_VALUE      <= '0;
            RSP_ERR        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner          <= grant_idx;
                        CS_VALUE_IN    <= sel_value;
                        CS_TARGET_SIGN <= sel_sign;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    wait_cnt <= sat_inc(wait_cnt);
                    if (CS_VALID_OUT) begin
                        RSP_VALUE <= CS_VALUE_OUT;
                        RSP_ERR   <= 1'b0;
                    end else if (wait_cnt == CNT_LAST) begin
                        RSP_VALUE <= '0;
                        RSP_ERR   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    rr_ptr <= rr_after(owner);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_sign_scheduler.sv
// Self-checking bench for fixed_point_sign_scheduler with a behavioural
// change-sign unit (configurable latency) and a round-robin reference model.
module tb_fixed_point_sign_scheduler;

    localparam int W  = 8;
    localparam int NR = 4;
    localparam int TO = 15;

    logic              CLK = 1'b0;
    logic              RSTN = 1'b0;
    logic [NR-1:0]     REQ_VALID = '0;
    logic [NR-1:0]     REQ_READY;
    logic [NR*W-1:0]   REQ_VALUE = '0;
    logic [NR-1:0]     REQ_SIGN = '0;
    logic [NR-1:0]     RSP_VALID;
    logic [W-1:0]      RSP_VALUE;
    logic              RSP_ERR;
    logic              CS_TARGET_SIGN;
    logic [W-1:0]      CS_VALUE_IN;
    logic              CS_VALID_IN;
    logic [W-1:0]      CS_VALUE_OUT = '0;
    logic              CS_VALID_OUT = 1'b0;
    logic              BUSY;

    int n_vec = 0;
    int n_err = 0;
    int exp_ptr = 0;

    // Change-sign unit model controls (written by tests only).
    int cs_lat  = 1;
    bit cs_echo = 1'b0;
    // Change-sign unit model state (written by the responder only).
    int         pend = 0;
    int         echo_left = 0;
    logic [W-1:0] pend_val = '0;

    fixed_point_sign_scheduler #(
        .WIDTH(W), .FRAC_BITS(3), .NUM_REQ(NR), .TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .RSTN(RSTN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_VALUE(REQ_VALUE), .REQ_SIGN(REQ_SIGN),
        .RSP_VALID(RSP_VALID), .RSP_VALUE(RSP_VALUE), .RSP_ERR(RSP_ERR),
        .CS_TARGET_SIGN(CS_TARGET_SIGN), .CS_VALUE_IN(CS_VALUE_IN),
        .CS_VALID_IN(CS_VALID_IN), .CS_VALUE_OUT(CS_VALUE_OUT),
        .CS_VALID_OUT(CS_VALID_OUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Result of forcing v to sign s (two's complement negate when it differs).
    function automatic logic [W-1:0] cs_model(input logic [W-1:0] v, input logic s);
        if (v == '0 || v[W-1] == s) return v;
        return 8'h00 - v;
    endfunction

    // First asserted requester at or after pointer p, wrapping; -1 if none.
    function automatic int rr_pick(input logic [NR-1:0] v, input int p);
        for (int i = 0; i < NR; i++) begin
            if (v[(p + i) % NR]) return (p + i) % NR;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NR-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [W-1:0] slot(input logic [NR*W-1:0] vals, input int g);
        return W'(vals >> (W * g));
    endfunction

    // Behavioural change-sign unit: answers L cycles after CS_VALID_IN
    // (L = 0 means never), optionally followed by two stray echo pulses.
    always @(negedge CLK) begin
        CS_VALID_OUT = 1'b0;
        if (echo_left > 0) begin
            CS_VALID_OUT = 1'b1;
            CS_VALUE_OUT = ~pend_val;
            echo_left--;
        end
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                CS_VALID_OUT = 1'b1;
                CS_VALUE_OUT = pend_val;
                if (cs_echo) echo_left = 2;
            end
        end
        if (CS_VALID_IN && cs_lat > 0) begin
            pend     = cs_lat;
            pend_val = cs_model(CS_VALUE_IN, CS_TARGET_SIGN);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge CLK);
        RSTN = 1'b0;
        REQ_VALID = '0;
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        exp_ptr = 0;
    endtask

    // Drives one transaction and observes it; returns what was seen.
    task automatic do_txn(input logic [NR-1:0] vld, input logic [NR*W-1:0] vals,
                          input logic [NR-1:0] sgn, input int lat, input bit hold,
                          output int gnt, output int ncyc, output logic [NR-1:0] rvec,
                          output logic [W-1:0] rval, output logic rerr,
                          output logic [W-1:0] csv, output logic css, output bit side_ok);
        gnt = -2; ncyc = -1; rvec = '0; rval = '0; rerr = 1'b0;
        csv = '0; css = 1'b0; side_ok = 1'b1;
        cs_lat = lat;
        @(negedge CLK);
        REQ_VALID = vld; REQ_VALUE = vals; REQ_SIGN = sgn;
        #1;
        for (int k = 0; k < 8 && gnt == -2; k++) begin
            if (REQ_READY !== '0) gnt = onehot_idx(REQ_READY);
            else begin @(negedge CLK); #1; end
        end
        if (gnt < 0) begin
            REQ_VALID = '0;
            return;
        end
        for (int k = 1; k <= TO + 8; k++) begin
            @(negedge CLK); #1;
            if (k == 1 && !hold) REQ_VALID = '0;
            if (k == 1) begin
                csv = CS_VALUE_IN; css = CS_TARGET_SIGN;
                if (CS_VALID_IN !== 1'b1) side_ok = 1'b0;
            end else if (CS_VALID_IN !== 1'b0) side_ok = 1'b0;
            if (REQ_READY !== '0 || BUSY !== 1'b1) side_ok = 1'b0;
            if (RSP_VALID !== '0) begin
                ncyc = k; rvec = RSP_VALID; rval = RSP_VALUE; rerr = RSP_ERR;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        REQ_VALID = '0;
        repeat (2) @(negedge CLK);
        #1;
        n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        n_vec++; if (RSP_VALID !== '0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0000", RSP_VALID); end
        n_vec++; if ({RSP_ERR, RSP_VALUE} !== 9'h0) begin n_err++; $display("FAIL reset_rsp: got err=%b val=%h want 0/00", RSP_ERR, RSP_VALUE); end
        n_vec++; if ({CS_VALID_IN, CS_TARGET_SIGN, CS_VALUE_IN} !== 10'h0) begin n_err++;
            $display("FAIL reset_cs: got vld=%b sgn=%b val=%h want 0/0/00", CS_VALID_IN, CS_TARGET_SIGN, CS_VALUE_IN); end
        n_vec++; if (REQ_READY !== '0) begin n_err++; $display("FAIL reset_ready: got %b want 0000", REQ_READY); end
        RSTN = 1'b1;
        exp_ptr = 0;
    endtask

    task automatic test_directed();
        int gnt, ncyc; logic [NR-1:0] rvec; logic [W-1:0] rval, csv; logic rerr, css; bit ok;
        // +2.0 forced negative, unit latency 3.
        do_txn(4'b0001, 32'h0000_0010, 4'b0001, 3, 1'b0, gnt, ncyc, rvec, rval, rerr, csv, css, ok);
        n_vec++; if (gnt !== 0) begin n_err++; $display("FAIL dir0_grant: got %0d want 0", gnt); end
        n_vec++; if (ncyc !== 5) begin n_err++; $display("FAIL dir0_latency: got %0d want 5", ncyc); end
        n_vec++; if ({rvec, rerr, rval} !== {4'b0001, 1'b0, 8'hF0}) begin n_err++;
            $display("FAIL dir0_rsp: got vec=%b err=%b val=%h want 0001/0/f0", rvec, rerr, rval); end
        n_vec++; if ({csv, css, ok} !== {8'h10, 1'b1, 1'b1}) begin n_err++;
            $display("FAIL dir0_issue: got cs=%h sgn=%b ok=%b want 10/1/1", csv, css, ok); end
        exp_ptr = 1;
        // -3.0 already negative, unit latency 1.
        do_txn(4'b0100, 32'h00E8_0000, 4'b0100, 1, 1'b0, gnt, ncyc, rvec, rval, rerr, csv, css, ok);
        n_vec++; if (gnt !== 2) begin n_err++; $display("FAIL dir2_grant: got %0d want 2", gnt); end
        n_vec++; if (ncyc !== 3) begin n_err++; $display("FAIL dir2_latency: got %0d want 3", ncyc); end
        n_vec++; if ({rvec, rerr, rval} !== {4'b0100, 1'b0, 8'hE8}) begin n_err++;
            $display("FAIL dir2_rsp: got vec=%b err=%b val=%h want 0100/0/e8", rvec, rerr, rval); end
        exp_ptr = 3;
    endtask

    task automatic test_round_robin();
        int gnt, ncyc; logic [NR-1:0] rvec; logic [W-1:0] rval, csv; logic rerr, css; bit ok;
        logic [NR*W-1:0] vals; logic [NR-1:0] sgn;
        int seen[NR];
        int want[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int i = 0; i < NR; i++) seen[i] = 0;
        vals = $urandom; sgn = 4'($urandom);
        for (int t = 0; t < 5; t++) begin
            do_txn(4'b1111, vals, sgn, 2, 1'b1, gnt, ncyc, rvec, rval, rerr, csv, css, ok);
            n_vec++; if (gnt !== want[t]) begin n_err++; $display("FAIL rr_order[%0d]: got %0d want %0d", t, gnt, want[t]); end
            if (gnt >= 0 && gnt < NR) begin
                if (t < 4) seen[gnt]++;
                n_vec++; if ({rvec, rerr, rval, ncyc} !== {NR'(1) << gnt, 1'b0, cs_model(slot(vals, gnt), sgn[gnt]), 32'd4}) begin n_err++;
                    $display("FAIL rr_rsp[%0d]: got vec=%b err=%b val=%h cyc=%0d", t, rvec, rerr, rval, ncyc); end
            end
        end
        REQ_VALID = '0;
        for (int i = 0; i < NR; i++) begin
            n_vec++; if (seen[i] !== 1) begin n_err++; $display("FAIL rr_fair[%0d]: got %0d responses want 1", i, seen[i]); end
        end
        exp_ptr = 1;
    endtask

    task automatic test_timeout();
        int gnt, ncyc; logic [NR-1:0] rvec; logic [W-1:0] rval, csv; logic rerr, css; bit ok;
        int lats[4] = '{0, TO, TO + 1, TO - 1};
        logic [NR*W-1:0] vals;
        for (int t = 0; t < 4; t++) begin
            bit tmo;
            int eg;
            int ec;
            vals = $urandom | 32'h0101_0101;
            eg = rr_pick(4'b0010, exp_ptr);
            tmo = (lats[t] == 0 || lats[t] > TO);
            ec = 2 + (tmo ? TO : lats[t]);
            do_txn(4'b0010, vals, 4'b0010, lats[t], 1'b0, gnt, ncyc, rvec, rval, rerr, csv, css, ok);
            n_vec++; if (ncyc !== ec) begin n_err++; $display("FAIL tmo_latency[L=%0d]: got %0d want %0d", lats[t], ncyc, ec); end
            n_vec++; if ({rvec, rerr, rval} !== {4'b0010, tmo, tmo ? 8'h00 : cs_model(slot(vals, 1), 1'b1)}) begin n_err++;
                $display("FAIL tmo_rsp[L=%0d]: got vec=%b err=%b val=%h", lats[t], rvec, rerr, rval); end
            n_vec++; if (ok !== 1'b1 || gnt !== eg) begin n_err++; $display("FAIL tmo_handshake[L=%0d]: got gnt=%0d ok=%b want %0d/1", lats[t], gnt, ok, eg); end
            exp_ptr = (eg + 1) % NR;
            if (t == 0) begin
                repeat (3) @(negedge CLK);
                #1;
                n_vec++; if ({RSP_VALID, RSP_ERR, RSP_VALUE} !== {4'b0000, 1'b1, 8'h00}) begin n_err++;
                    $display("FAIL tmo_hold: got vec=%b err=%b val=%h want 0000/1/00", RSP_VALID, RSP_ERR, RSP_VALUE); end
            end
        end
    endtask

    task automatic test_stray();
        int gnt, ncyc; logic [NR-1:0] rvec; logic [W-1:0] rval, csv, ev; logic rerr, css; bit ok;
        logic [NR*W-1:0] vals;
        int bad = 0;
        vals = $urandom;
        ev = cs_model(slot(vals, 3), 1'b0);
        cs_echo = 1'b1;
        do_txn(4'b1000, vals, 4'b0000, 2, 1'b0, gnt, ncyc, rvec, rval, rerr, csv, css, ok);
        cs_echo = 1'b0;
        exp_ptr = 0;
        n_vec++; if ({rvec, rerr, rval, ncyc} !== {4'b1000, 1'b0, ev, 32'd4}) begin n_err++;
            $display("FAIL stray_rsp: got vec=%b err=%b val=%h cyc=%0d want 1000/0/%h/4", rvec, rerr, rval, ncyc, ev); end
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK); #1;
            if (RSP_VALID !== '0 || BUSY !== 1'b0) bad++;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL stray_ignored: got %0d bad cycles want 0", bad); end
        n_vec++; if (RSP_VALUE !== ev) begin n_err++; $display("FAIL stray_hold: got %h want %h", RSP_VALUE, ev); end
    endtask

    task automatic test_reset_mid();
        int gnt, ncyc; logic [NR-1:0] rvec; logic [W-1:0] rval, csv; logic rerr, css; bit ok;
        logic [NR*W-1:0] vals;
        int bad = 0;
        int waited = 0;
        vals = $urandom;
        do_txn(4'b0010, vals, 4'b0000, 2, 1'b0, gnt, ncyc, rvec, rval, rerr, csv, css, ok);
        // Start an operation on requester 2 whose result comes back late.
        cs_lat = 8;
        @(negedge CLK);
        REQ_VALID = 4'b0100; REQ_VALUE = vals; REQ_SIGN = 4'b0100;
        #1;
        while (REQ_READY === '0 && waited < 8) begin @(negedge CLK); #1; waited++; end
        n_vec++; if (REQ_READY !== 4'b0100) begin n_err++; $display("FAIL rstmid_grant: got %b want 0100", REQ_READY); end
        @(negedge CLK);
        REQ_VALID = '0;
        repeat (3) @(negedge CLK);
        RSTN = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        n_vec++; if ({BUSY, RSP_VALID} !== 5'b0) begin n_err++; $display("FAIL rstmid_state: got busy=%b vec=%b want 0/0000", BUSY, RSP_VALID); end
        RSTN = 1'b1;
        exp_ptr = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK); #1;
            if (RSP_VALID !== '0 || BUSY !== 1'b0) bad++;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL rstmid_late: got %0d bad cycles want 0", bad); end
        n_vec++; if ({RSP_ERR, RSP_VALUE} !== 9'h0) begin n_err++; $display("FAIL rstmid_rsp: got err=%b val=%h want 0/00", RSP_ERR, RSP_VALUE); end
        vals = $urandom;
        do_txn(4'b1111, vals, 4'b0001, 3, 1'b0, gnt, ncyc, rvec, rval, rerr, csv, css, ok);
        n_vec++; if (gnt !== 0) begin n_err++; $display("FAIL rstmid_ptr: got grant %0d want 0", gnt); end
        n_vec++; if ({rvec, rerr, rval, ncyc} !== {4'b0001, 1'b0, cs_model(slot(vals, 0), 1'b1), 32'd5}) begin n_err++;
            $display("FAIL rstmid_next: got vec=%b err=%b val=%h cyc=%0d", rvec, rerr, rval, ncyc); end
        exp_ptr = 1;
    endtask

    task automatic test_random();
        int gnt, ncyc; logic [NR-1:0] rvec; logic [W-1:0] rval, csv; logic rerr, css; bit ok;
        for (int t = 0; t < 24; t++) begin
            logic [NR-1:0] vld, sgn;
            logic [NR*W-1:0] vals;
            int lat, eg, ec;
            bit tmo;
            vld  = NR'($urandom_range(1, 15));
            sgn  = NR'($urandom);
            vals = $urandom;
            lat  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO + 2);
            eg   = rr_pick(vld, exp_ptr);
            tmo  = (lat == 0 || lat > TO);
            ec   = 2 + (tmo ? TO : lat);
            do_txn(vld, vals, sgn, lat, 1'b0, gnt, ncyc, rvec, rval, rerr, csv, css, ok);
            n_vec++; if (gnt !== eg) begin n_err++; $display("FAIL rnd_grant[%0d]: got %0d want %0d (vld=%b)", t, gnt, eg, vld); end
            n_vec++; if (ncyc !== ec) begin n_err++; $display("FAIL rnd_latency[%0d]: got %0d want %0d (L=%0d)", t, ncyc, ec, lat); end
            n_vec++; if ({csv, css, ok} !== {slot(vals, eg), sgn[eg], 1'b1}) begin n_err++;
                $display("FAIL rnd_issue[%0d]: got cs=%h sgn=%b ok=%b want %h/%b/1", t, csv, css, ok, slot(vals, eg), sgn[eg]); end
            n_vec++; if ({rvec, rerr, rval} !== {NR'(1) << eg, tmo, tmo ? 8'h00 : cs_model(slot(vals, eg), sgn[eg])}) begin n_err++;
                $display("FAIL rnd_rsp[%0d]: got vec=%b err=%b val=%h (L=%0d)", t, rvec, rerr, rval, lat); end
            exp_ptr = (eg + 1) % NR;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_round_robin();
        test_timeout();
        test_stray();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
